// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - MEM-stage load/store request and response bundle
interface data_mem_ctrl_if;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        access_fault;

    modport master (
        output mem_read, mem_write, funct3, addr, wdata,
        input  rdata, stall, access_fault
    );

    modport slave (
        input  mem_read, mem_write, funct3, addr, wdata,
        output rdata, stall, access_fault
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - MEM-stage data RAM responder with wait states, stall and access faults
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_ctrl_if.slave bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic        req;
    logic        is_store;
    logic        f3_ok;
    logic        misaligned;
    logic        out_of_range;
    logic        fault;
    logic        start;
    logic        commit;
    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0] word_rd;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] load_val;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [31:0] rdata_q;

    // A store is flagged by mem_write alone; the decoder also raises mem_read on stores
    assign req          = bus.mem_read | bus.mem_write;
    assign is_store     = bus.mem_write;
    assign misaligned   = ((bus.funct3[1:0] == 2'b01) & bus.addr[0]) |
                          ((bus.funct3[1:0] == 2'b10) & (bus.addr[1:0] != 2'b00));
    assign out_of_range = {2'b00, bus.addr[31:2]} >= 32'(DEPTH_WORDS);
    assign fault        = req & (~f3_ok | misaligned | out_of_range);
    assign start        = (state == S_IDLE) & req & ~fault;

    // Outputs are forced quiet while reset is held, even if a request is still presented
    assign bus.stall        = rst_n & (start | (state == S_WAIT));
    assign bus.access_fault = rst_n & (state == S_IDLE) & fault;
    assign bus.rdata        = rdata_q;

    // Legal size/sign codes: unsigned variants exist only for loads
    always_comb begin
        f3_ok = 1'b0;
        case (bus.funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = ~is_store;
            default:                f3_ok = 1'b0;
        endcase
    end

    // Next state; commit marks the edge that enters RESP, where the access takes effect
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = S_RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = S_RESP;
                    commit    = 1'b1;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Wait-state down-counter, loaded when a request is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             cnt <= 3'd0;
        else if (start)                         cnt <= CNT_INIT;
        else if (state == S_WAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
    end

    assign idx     = bus.addr[AW+1:2];
    assign word_rd = mem[idx];
    assign ld_b    = 8'(word_rd >> {bus.addr[1:0], 3'b000});
    assign ld_h    = bus.addr[1] ? word_rd[31:16] : word_rd[15:0];

    // Load lane selection and sign/zero extension
    always_comb begin
        load_val = word_rd;
        case (bus.funct3)
            3'b000:  load_val = {{24{ld_b[7]}}, ld_b};
            3'b001:  load_val = {{16{ld_h[15]}}, ld_h};
            3'b100:  load_val = {24'h0, ld_b};
            3'b101:  load_val = {16'h0, ld_h};
            default: load_val = word_rd;
        endcase
    end

    // Store byte enables; data is replicated so every enabled lane sees the right bits
    always_comb begin
        wr_be   = 4'b1111;
        wr_data = bus.wdata;
        case (bus.funct3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << bus.addr[1:0];
                wr_data = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = bus.addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{bus.wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_data = bus.wdata;
            end
        endcase
    end

    // RAM write on commit; gated by rst_n so an interrupted store never lands
    always_ff @(posedge clk) begin
        if (commit && is_store && rst_n) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Load result register, held until the next completed load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  rdata_q <= 32'h0;
        else if (commit && !is_store) rdata_q <= load_val;
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl (WAIT_STATES 0 and 1 builds)
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    data_mem_ctrl_if ifc0();
    data_mem_ctrl_if ifc1();

    logic        rd_d [2];
    logic        wr_d [2];
    logic [2:0]  f3_d [2];
    logic [31:0] a_d  [2];
    logic [31:0] wd_d [2];

    assign ifc0.mem_read  = rd_d[0];
    assign ifc0.mem_write = wr_d[0];
    assign ifc0.funct3    = f3_d[0];
    assign ifc0.addr      = a_d[0];
    assign ifc0.wdata     = wd_d[0];
    assign ifc1.mem_read  = rd_d[1];
    assign ifc1.mem_write = wr_d[1];
    assign ifc1.funct3    = f3_d[1];
    assign ifc1.addr      = a_d[1];
    assign ifc1.wdata     = wd_d[1];

    data_mem_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(ifc0)
    );
    data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(ifc1)
    );

    logic [68:0] bus_w1;
    assign bus_w1 = {rd_d[1], wr_d[1], f3_d[1], a_d[1], wd_d[1]};

    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
                             (ifc1.stall && $past(ifc1.stall)) |-> $stable(bus_w1))
        else $error("protocol violation on dut1: request changed while stalled");

    int nchk = 0;
    int nerr = 0;

    logic [7:0]  mb  [2][128];
    logic [31:0] mrd [2];
    int          depth [2] = '{64, 1024};
    int          ws    [2] = '{0, 1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input int s);
        return (s == 1) ? ifc1.rdata : ifc0.rdata;
    endfunction
    function automatic logic stall_of(input int s);
        return (s == 1) ? ifc1.stall : ifc0.stall;
    endfunction
    function automatic logic fault_of(input int s);
        return (s == 1) ? ifc1.access_fault : ifc0.access_fault;
    endfunction

    function automatic bit exp_fault(input int s, input logic wr, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        int n;
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n = 1 << f3[1:0];
        return !legal || ((a % n) != 0) || ((a >> 2) >= depth[s]);
    endfunction

    function automatic logic [31:0] exp_load(input int s, input logic [2:0] f3, input logic [31:0] a);
        int n;
        logic [31:0] v;
        n = 1 << f3[1:0];
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[s][a + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic exec(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
        bit f;
        int cyc;
        f = exp_fault(s, wr, f3, a);
        @(negedge clk);
        rd_d[s] = rd; wr_d[s] = wr; f3_d[s] = f3; a_d[s] = a; wd_d[s] = wd;
        #1;
        chk("access_fault", 32'(fault_of(s)), 32'(f));
        if (f) begin
            chk("stall_on_fault", 32'(stall_of(s)), 32'd0);
            @(posedge clk); #1;
            chk("fault_held", 32'(fault_of(s)), 32'd1);
            chk("rdata_kept_on_fault", rdata_of(s), mrd[s]);
        end else begin
            cyc = 0;
            while (stall_of(s) && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("stall_cycles", 32'(cyc), 32'(ws[s] + 1));
            if (wr) begin
                for (int i = 0; i < (1 << f3[1:0]); i++) mb[s][a + i] = wd[8*i +: 8];
            end else begin
                mrd[s] = exp_load(s, f3, a);
            end
            chk(wr ? "rdata_after_store" : "rdata_after_load", rdata_of(s), mrd[s]);
        end
        @(negedge clk);
        rd_d[s] = 1'b0; wr_d[s] = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_stall", 32'(stall_of(s)), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        wr;
        logic        rd;
        logic [2:0]  f3;
        logic [31:0] a;
        rst_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            rd_d[s] = 1'b0; wr_d[s] = 1'b0; f3_d[s] = 3'b0; a_d[s] = 32'h0; wd_d[s] = 32'h0;
            mrd[s] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("reset_rdata", rdata_of(s), 32'h0);
            chk("reset_stall", 32'(stall_of(s)), 32'd0);
            chk("reset_fault", 32'(fault_of(s)), 32'd0);
        end

        exec(1, 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        exec(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("lw_0x10", rdata_of(1), 32'hDEADBEEF);
        exec(1, 1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
        chk("lb_0x13", rdata_of(1), 32'hFFFFFFDE);
        exec(1, 1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
        chk("lbu_0x13", rdata_of(1), 32'h000000DE);
        exec(1, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
        chk("lh_0x12", rdata_of(1), 32'hFFFFDEAD);
        exec(1, 1'b1, 1'b0, 3'b101, 32'h10, 32'h0);
        chk("lhu_0x10", rdata_of(1), 32'h0000BEEF);

        exec(1, 1'b0, 1'b1, 3'b000, 32'h11, 32'h00000055);
        exec(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("sb_then_lw", rdata_of(1), 32'hDEAD55EF);
        exec(1, 1'b0, 1'b1, 3'b001, 32'h12, 32'h00001234);
        exec(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("sh_then_lw", rdata_of(1), 32'h123455EF);

        exec(1, 1'b1, 1'b0, 3'b010, 32'h12, 32'h0);
        exec(1, 1'b0, 1'b1, 3'b001, 32'h11, 32'hFFFF_FFFF);
        exec(1, 1'b1, 1'b0, 3'b010, 32'd4096, 32'h0);
        exec(1, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
        exec(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("word_after_faults", rdata_of(1), 32'h123455EF);

        exec(1, 1'b1, 1'b1, 3'b010, 32'h20, 32'hA5A5A5A5);
        exec(1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        chk("both_is_store", rdata_of(1), 32'hA5A5A5A5);

        @(negedge clk);
        rd_d[1] = 1'b0; wr_d[1] = 1'b1; f3_d[1] = 3'b010; a_d[1] = 32'h10; wd_d[1] = 32'h0;
        @(posedge clk); #1;
        chk("wait_stall", 32'(stall_of(1)), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(stall_of(1)), 32'd0);
        chk("rst_mid_rdata", rdata_of(1), 32'h0);
        chk("rst_mid_rdata_dut0", rdata_of(0), 32'h0);
        mrd[0] = 32'h0;
        mrd[1] = 32'h0;
        @(negedge clk);
        wr_d[1] = 1'b0;
        rst_n = 1'b1;
        exec(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        chk("store_dropped_by_reset", rdata_of(1), 32'h123455EF);

        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 32; w++) exec(s, 1'b0, 1'b1, 3'b010, 32'(4 * w), $urandom);
        end
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 150; k++) begin
                wr = 1'($urandom_range(0, 1));
                rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
                f3 = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 7) == 0) a = 32'(depth[s] * 4) + 32'($urandom_range(0, 4095));
                else                           a = 32'($urandom_range(0, 127));
                exec(s, rd, wr, f3, a, $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
